// File: rtl/next_pc_unit_pkg.sv
// Shared CPU definitions for the fetch-address path: datapath width,
// sequential PC increment, branch target source and PC state encodings.
package next_pc_unit_pkg;

    // Architectural datapath width
    localparam int unsigned XLEN = 64;

    // Sequential fetch advances one 32-bit instruction
    localparam logic [XLEN-1:0] PC_INC = 64'd4;

    // Branch target source selector
    typedef enum logic [1:0] {
        BR_IMM26  = 2'b00,
        BR_COND19 = 2'b01,
        BR_REG    = 2'b10
    } br_sel_t;

    // Fetch state: normal run or post-redirect fetch bubble
    typedef enum logic {
        RUN    = 1'b0,
        BUBBLE = 1'b1
    } pc_state_t;

    // Raw selector to enum; the reserved code 2'b11 behaves as a register target
    function automatic br_sel_t decode_br_sel(input logic [1:0] raw);
        br_sel_t sel;
        case (raw)
            2'b00:   sel = BR_IMM26;
            2'b01:   sel = BR_COND19;
            default: sel = BR_REG;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/next_pc_unit_branch_target_calc.sv
// Combinational branch target generator. PC-relative targets are the
// branch PC plus the word offset scaled to bytes; register targets pass
// through untouched. Shared with the EX stage for branch verification.
module branch_target_calc
    import next_pc_unit_pkg::*;
(
    input  logic [1:0]      br_sel,
    input  logic [XLEN-1:0] base,
    input  logic [XLEN-1:0] br26_se,
    input  logic [XLEN-1:0] cond19_se,
    input  logic [XLEN-1:0] reg_addr,
    output logic [XLEN-1:0] target
);

    br_sel_t         sel;
    logic [XLEN-1:0] offset;
    logic [XLEN-1:0] rel_target;

    // Pick the offset, then one shared 64-bit adder; carries out of bit 63 are dropped
    always_comb begin
        sel        = decode_br_sel(br_sel);
        offset     = (sel == BR_IMM26) ? br26_se : cond19_se;
        rel_target = base + (offset << 2);
        target     = (sel == BR_REG) ? reg_addr : rel_target;
    end

endmodule

// File: rtl/next_pc_unit.sv
// Program counter register and next-PC generator. Applies taken-branch
// redirects (highest priority), hazard stalls and sequential increment,
// and marks a configurable number of fetch bubbles invalid after each
// redirect.
module next_pc_unit
    import next_pc_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 64'h0,
    parameter int unsigned     BUBBLES  = 1
)(
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            br_taken,
    input  logic [1:0]      br_sel,
    input  logic [XLEN-1:0] br_base_pc,
    input  logic [XLEN-1:0] br26_se,
    input  logic [XLEN-1:0] cond19_se,
    input  logic [XLEN-1:0] br_reg_addr,
    output logic [XLEN-1:0] pc,
    output logic            pc_valid,
    output logic            redirect
);

    // Counter starts at BUBBLES-1 so that BUBBLES invalid cycles elapse
    localparam logic       HAS_BUBBLES = (BUBBLES != 0);
    localparam logic [1:0] CNT_RELOAD  = (BUBBLES == 0) ? 2'd0 : 2'(BUBBLES - 1);

    logic [XLEN-1:0] target;

    logic [XLEN-1:0] pc_q, pc_d;
    logic            valid_q, valid_d;
    logic            redirect_q, redirect_d;
    pc_state_t       state_q, state_d;
    logic [1:0]      cnt_q, cnt_d;

    branch_target_calc u_target (
        .br_sel    (br_sel),
        .base      (br_base_pc),
        .br26_se   (br26_se),
        .cond19_se (cond19_se),
        .reg_addr  (br_reg_addr),
        .target    (target)
    );

    // Next-state: branch beats stall beats sequential; bubbles count down regardless of stall
    always_comb begin
        pc_d       = pc_q;
        valid_d    = valid_q;
        state_d    = state_q;
        cnt_d      = cnt_q;
        redirect_d = 1'b0;

        if (br_taken) begin
            pc_d       = target;
            redirect_d = 1'b1;
            if (HAS_BUBBLES) begin
                state_d = BUBBLE;
                cnt_d   = CNT_RELOAD;
                valid_d = 1'b0;
            end else begin
                state_d = RUN;
                cnt_d   = '0;
                valid_d = 1'b1;
            end
        end else begin
            case (state_q)
                RUN: begin
                    valid_d = 1'b1;
                    if (!stall) begin
                        pc_d = pc_q + PC_INC;
                    end
                end
                BUBBLE: begin
                    // pc holds the target so it is the first valid fetch
                    if (cnt_q == '0) begin
                        state_d = RUN;
                        valid_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 2'd1;
                    end
                end
                default: begin
                    state_d = RUN;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State and registered outputs; reset is asynchronous active-low
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q       <= RESET_PC;
            valid_q    <= 1'b1;
            redirect_q <= 1'b0;
            state_q    <= RUN;
            cnt_q      <= '0;
        end else begin
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            redirect_q <= redirect_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
        end
    end

    assign pc       = pc_q;
    assign pc_valid = valid_q;
    assign redirect = redirect_q;

endmodule

// File: tb/tb_next_pc_unit.sv
// Self-checking bench for next_pc_unit: two instances (one and two bubbles)
// share stimulus and are checked every cycle against a behavioural model,
// with literal expectations pinning the directed scenarios.
module tb_next_pc_unit;

    localparam logic [63:0] RST_PC = 64'h1000;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        br_taken;
    logic [1:0]  br_sel;
    logic [63:0] br_base_pc, br26_se, cond19_se, br_reg_addr;

    logic [63:0] pc1, pc2;
    logic        v1, v2, r1, r2;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    next_pc_unit #(.RESET_PC(RST_PC), .BUBBLES(1)) dut1 (
        .clk(clk), .reset(reset), .stall(stall), .br_taken(br_taken), .br_sel(br_sel),
        .br_base_pc(br_base_pc), .br26_se(br26_se), .cond19_se(cond19_se),
        .br_reg_addr(br_reg_addr), .pc(pc1), .pc_valid(v1), .redirect(r1)
    );

    next_pc_unit #(.RESET_PC(RST_PC), .BUBBLES(2)) dut2 (
        .clk(clk), .reset(reset), .stall(stall), .br_taken(br_taken), .br_sel(br_sel),
        .br_base_pc(br_base_pc), .br26_se(br26_se), .cond19_se(cond19_se),
        .br_reg_addr(br_reg_addr), .pc(pc2), .pc_valid(v2), .redirect(r2)
    );

    // Behavioural model: pending = invalid fetch cycles still owed after a redirect
    logic [63:0] m_pc   [2];
    int          m_pend [2];
    logic        m_redir[2];
    int          m_bub  [2] = '{1, 2};

    function automatic logic [63:0] model_target();
        case (br_sel)
            2'd0:    return br_base_pc + br26_se * 64'd4;
            2'd1:    return br_base_pc + cond19_se * 64'd4;
            default: return br_reg_addr;
        endcase
    endfunction

    always @(posedge clk or negedge reset) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset) begin
                m_pc[i]    <= RST_PC;
                m_pend[i]  <= 0;
                m_redir[i] <= 1'b0;
            end else if (br_taken) begin
                m_pc[i]    <= model_target();
                m_pend[i]  <= m_bub[i];
                m_redir[i] <= 1'b1;
            end else begin
                m_redir[i] <= 1'b0;
                if (m_pend[i] > 0)
                    m_pend[i] <= m_pend[i] - 1;
                else if (!stall)
                    m_pc[i] <= m_pc[i] + 64'd4;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from both clock edges
    always begin
        @(negedge clk);
        #3;
        if (chk_en) begin
            chk("m1.pc", pc1, m_pc[0]);
            chk("m1.valid", 64'(v1), 64'(m_pend[0] == 0));
            chk("m1.redirect", 64'(r1), 64'(m_redir[0]));
            chk("m2.pc", pc2, m_pc[1]);
            chk("m2.valid", 64'(v2), 64'(m_pend[1] == 0));
            chk("m2.redirect", 64'(r2), 64'(m_redir[1]));
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic branch(input logic [1:0] sel, input logic [63:0] base,
                          input logic [63:0] b26, input logic [63:0] c19,
                          input logic [63:0] ra);
        br_taken    = 1'b1;
        br_sel      = sel;
        br_base_pc  = base;
        br26_se     = b26;
        cond19_se   = c19;
        br_reg_addr = ra;
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; br_taken = 1'b0; br_sel = 2'd0;
        br_base_pc = '0; br26_se = '0; cond19_se = '0; br_reg_addr = '0;

        // Reset state and sequential run
        tick(); tick();
        chk_en = 1'b1;
        chk("rst.pc", pc1, 64'h1000);
        chk("rst.valid", 64'(v1), 64'd1);
        chk("rst.redirect", 64'(r1), 64'd0);
        chk("rst.pc2", pc2, 64'h1000);
        reset = 1'b1;
        tick(); chk("seq.1004", pc1, 64'h1004); chk("seq.redir", 64'(r1), 64'd0);
        tick(); chk("seq.1008", pc1, 64'h1008);
        tick(); chk("seq.100c", pc1, 64'h100C); chk("seq.100c.b2", pc2, 64'h100C);
        chk("seq.valid", 64'(v1), 64'd1);

        // Park both instances at 0x2000
        branch(2'd2, '0, '0, '0, 64'h2000);
        tick(); chk("reg.pc", pc1, 64'h2000); chk("reg.redir", 64'(r1), 64'd1);
        chk("reg.valid", 64'(v1), 64'd0);
        br_taken = 1'b0; stall = 1'b1;
        tick(); tick();
        chk("park.pc2", pc2, 64'h2000); chk("park.v2", 64'(v2), 64'd1);

        // Conditional branch with negative offset
        stall = 1'b0;
        branch(2'd1, 64'h2000, '0, 64'hFFFF_FFFF_FFFF_FFFE, '0);
        tick(); chk("c19.pc", pc1, 64'h1FF8); chk("c19.redir", 64'(r1), 64'd1);
        chk("c19.bub", 64'(v1), 64'd0);
        br_taken = 1'b0;
        tick(); chk("c19.tgt", pc1, 64'h1FF8); chk("c19.v", 64'(v1), 64'd1);
        chk("c19.redir0", 64'(r1), 64'd0); chk("c19.v2", 64'(v2), 64'd0);
        tick(); chk("c19.next", pc1, 64'h1FFC); chk("c19.pc2", pc2, 64'h1FF8);
        chk("c19.v2b", 64'(v2), 64'd1);

        // Wrap of target adder and of sequential increment
        branch(2'd0, 64'hFFFF_FFFF_FFFF_FFF0, 64'h8, '0, '0);
        tick(); chk("wrap.tgt", pc1, 64'h10);
        branch(2'd2, '0, '0, '0, 64'hFFFF_FFFF_FFFF_FFFC);
        tick(); chk("wrap.top", pc1, 64'hFFFF_FFFF_FFFF_FFFC);
        br_taken = 1'b0; stall = 1'b1;
        tick(); tick();
        stall = 1'b0;
        tick(); chk("wrap.seq", pc1, 64'h0); chk("wrap.seq2", pc2, 64'h0);

        // Stall holds, then branch beats stall
        branch(2'd2, '0, '0, '0, 64'h3000);
        tick();
        br_taken = 1'b0; stall = 1'b1;
        tick(); tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall.pc", pc1, 64'h3000);
            chk("stall.v", 64'(v1), 64'd1);
        end
        branch(2'd2, '0, '0, '0, 64'h4000);
        tick(); chk("bvs.pc", pc1, 64'h4000); chk("bvs.redir", 64'(r1), 64'd1);
        chk("bvs.pc2", pc2, 64'h4000);

        // Re-branch during first of two bubbles
        stall = 1'b0;
        branch(2'd2, '0, '0, '0, 64'h4400);
        tick(); chk("rb.first", pc2, 64'h4400);
        branch(2'd2, '0, '0, '0, 64'h5000);
        tick(); chk("rb.pc", pc2, 64'h5000); chk("rb.redir", 64'(r2), 64'd1);
        chk("rb.v0", 64'(v2), 64'd0);
        br_taken = 1'b0;
        tick(); chk("rb.v1", 64'(v2), 64'd0); chk("rb.redir0", 64'(r2), 64'd0);
        tick(); chk("rb.v2", 64'(v2), 64'd1); chk("rb.pc2", pc2, 64'h5000);

        // Asynchronous reset during a bubble
        branch(2'd2, '0, '0, '0, 64'h6000);
        tick();
        br_taken = 1'b0;
        #1 reset = 1'b0;
        #1;
        chk("arst.pc", pc2, 64'h1000); chk("arst.v", 64'(v2), 64'd1);
        chk("arst.redir", 64'(r2), 64'd0); chk("arst.pc1", pc1, 64'h1000);
        tick();
        reset = 1'b1;

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            tick();
            reset       = ($urandom_range(0, 63) != 0);
            stall       = ($urandom_range(0, 9) < 3);
            br_taken    = ($urandom_range(0, 3) == 0);
            br_sel      = 2'($urandom_range(0, 3));
            br_base_pc  = {$urandom, $urandom};
            br26_se     = ($urandom_range(0, 1) == 1) ? {$urandom, $urandom}
                                                      : 64'($signed(8'($urandom)));
            cond19_se   = {$urandom, $urandom};
            br_reg_addr = {$urandom, $urandom};
        end
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
